// File: rtl/sram_arbiter_if.sv
// Bundle of every signal between the two masters, the arbiter and the SRAM
// controller. The arbiter connects through the slave modport; whatever
// drives the masters and the controller connects through the master modport.
//
// Handshake: a master raises req together with wren/addr/wdata/bmask and
// holds all of them steady until it sees its one-cycle ack. In the cycle
// after the ack it either drops req or presents a new command; a req still
// high in that cycle counts as a new request. rdata and err are only
// meaningful while the matching ack is high. On the controller side the
// arbiter holds one strobe (wren or rden) high until i_s_ack comes back, or
// until the watchdog gives up on the access.
interface sram_arbiter_if;
  // instruction-fetch master (M0)
  logic        i_m0_req;
  logic        i_m0_wren;
  logic [31:0] i_m0_addr;
  logic [31:0] i_m0_wdata;
  logic [3:0]  i_m0_bmask;
  logic        o_m0_ack;
  logic [31:0] o_m0_rdata;
  logic        o_m0_err;
  // LSU data master (M1)
  logic        i_m1_req;
  logic        i_m1_wren;
  logic [31:0] i_m1_addr;
  logic [31:0] i_m1_wdata;
  logic [3:0]  i_m1_bmask;
  logic        o_m1_ack;
  logic [31:0] o_m1_rdata;
  logic        o_m1_err;
  // SRAM controller side
  logic [31:0] o_s_addr;
  logic [31:0] o_s_wdata;
  logic [3:0]  o_s_bmask;
  logic        o_s_wren;
  logic        o_s_rden;
  logic [31:0] i_s_rdata;
  logic        i_s_ack;
  // status
  logic        o_busy;

  modport slave (
    input  i_m0_req, i_m0_wren, i_m0_addr, i_m0_wdata, i_m0_bmask,
    input  i_m1_req, i_m1_wren, i_m1_addr, i_m1_wdata, i_m1_bmask,
    input  i_s_rdata, i_s_ack,
    output o_m0_ack, o_m0_rdata, o_m0_err,
    output o_m1_ack, o_m1_rdata, o_m1_err,
    output o_s_addr, o_s_wdata, o_s_bmask, o_s_wren, o_s_rden,
    output o_busy
  );

  modport master (
    output i_m0_req, i_m0_wren, i_m0_addr, i_m0_wdata, i_m0_bmask,
    output i_m1_req, i_m1_wren, i_m1_addr, i_m1_wdata, i_m1_bmask,
    output i_s_rdata, i_s_ack,
    input  o_m0_ack, o_m0_rdata, o_m0_err,
    input  o_m1_ack, o_m1_rdata, o_m1_err,
    input  o_s_addr, o_s_wdata, o_s_bmask, o_s_wren, o_s_rden,
    input  o_busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter in front of the single SRAM controller.
// M0 is instruction fetch, M1 is the LSU. The winner's command is latched
// on the grant edge and held on the controller side until the controller
// acks or the watchdog expires. Acks and read data are combinational from
// the controller's ack, so the return path adds no latency.
module sram_arbiter #(
  parameter int TIMEOUT = 255  // BUSY cycles without ack before abort, 1..255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sram_arbiter_if.slave        bus,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  // Counter value at which the access is abandoned; with the counter
  // cleared on grant this is the (TIMEOUT+1)th BUSY cycle.
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic        last_q, last_d;          // most recently granted master
  logic [7:0]  cnt_q, cnt_d;            // watchdog
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic [3:0]  cmd_bmask_q, cmd_bmask_d;
  logic        cmd_wren_q, cmd_wren_d;

  // Shared decode of the current access
  logic        in_busy;
  logic        owner;                   // 0 = M0, 1 = M1 (valid in BUSY)
  logic        s_done;                  // controller acked this cycle
  logic        wd_fire;                 // watchdog expired without ack
  logic        grant_m0;
  logic        grant_m1;

  // Classify the current cycle: who owns the bus and how the access ends
  always_comb begin
    in_busy  = (state_q != IDLE);
    owner    = (state_q == BUSY1);
    s_done   = in_busy && bus.i_s_ack;
    wd_fire  = in_busy && !bus.i_s_ack && (cnt_q == TO_LIMIT);
    // Round-robin: a lone request wins; a tie goes to the master that was
    // not granted last.
    grant_m0 = 1'b0;
    grant_m1 = 1'b0;
    if (bus.i_m0_req && bus.i_m1_req) begin
      grant_m0 = last_q;
      grant_m1 = !last_q;
    end else begin
      grant_m0 = bus.i_m0_req;
      grant_m1 = bus.i_m1_req;
    end
  end

  // Next-state logic: grant from IDLE, finish on ack or watchdog
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_bmask_d = cmd_bmask_q;
    cmd_wren_d  = cmd_wren_q;
    case (state_q)
      IDLE: begin
        // A late controller ack here is simply not looked at.
        if (grant_m0) begin
          state_d     = BUSY0;
          last_d      = 1'b0;
          cnt_d       = 8'd0;
          cmd_addr_d  = bus.i_m0_addr;
          cmd_wdata_d = bus.i_m0_wdata;
          cmd_bmask_d = bus.i_m0_bmask;
          cmd_wren_d  = bus.i_m0_wren;
        end else if (grant_m1) begin
          state_d     = BUSY1;
          last_d      = 1'b1;
          cnt_d       = 8'd0;
          cmd_addr_d  = bus.i_m1_addr;
          cmd_wdata_d = bus.i_m1_wdata;
          cmd_bmask_d = bus.i_m1_bmask;
          cmd_wren_d  = bus.i_m1_wren;
        end
      end
      BUSY0, BUSY1: begin
        // Requests are ignored here; the command registers stay frozen.
        if (s_done || wd_fire) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, priority, watchdog and command registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cnt_q       <= 8'd0;
      cmd_addr_q  <= 32'd0;
      cmd_wdata_q <= 32'd0;
      cmd_bmask_q <= 4'd0;
      cmd_wren_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_bmask_q <= cmd_bmask_d;
      cmd_wren_q  <= cmd_wren_d;
    end
  end

  // Controller-side outputs: latched command, one strobe while the access
  // is live; the strobes drop in the watchdog cycle and asynchronously on
  // reset because they decode the state register directly.
  always_comb begin
    bus.o_s_addr  = cmd_addr_q;
    bus.o_s_wdata = cmd_wdata_q;
    bus.o_s_bmask = cmd_bmask_q;
    bus.o_s_wren  = 1'b0;
    bus.o_s_rden  = 1'b0;
    if (in_busy && !wd_fire) begin
      bus.o_s_wren = cmd_wren_q;
      bus.o_s_rden = !cmd_wren_q;
    end
    bus.o_busy    = in_busy;
    o_dbg_state   = state_q;
  end

  // Master-side return path: ack/data/err go only to the owner. A real
  // controller ack beats a watchdog expiry landing in the same cycle.
  always_comb begin
    bus.o_m0_ack   = 1'b0;
    bus.o_m0_err   = 1'b0;
    bus.o_m0_rdata = 32'd0;
    bus.o_m1_ack   = 1'b0;
    bus.o_m1_err   = 1'b0;
    bus.o_m1_rdata = 32'd0;
    if (!owner) begin
      bus.o_m0_ack   = s_done || wd_fire;
      bus.o_m0_err   = wd_fire;
      bus.o_m0_rdata = s_done ? bus.i_s_rdata : 32'd0;
    end else begin
      bus.o_m1_ack   = s_done || wd_fire;
      bus.o_m1_err   = wd_fire;
      bus.o_m1_rdata = s_done ? bus.i_s_rdata : 32'd0;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios, a cycle-level reference model
// compared every cycle, and a queue of hand-computed completions.
module tb_sram_arbiter;

  localparam int TIMEOUT = 4;
  localparam int W       = 34;   // {master, err, rdata}

  // ---------------- clock / reset ----------------
  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [1:0] dbg_state;

  sram_arbiter_if bus ();

  sram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial forever #5 i_clk = ~i_clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_rden   = 0;
  int n_ack0   = 0;
  int n_ack1   = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_m0_req = 0; bus.i_m0_wren = 0; bus.i_m0_addr = 0; bus.i_m0_wdata = 0; bus.i_m0_bmask = 0;
    bus.i_m1_req = 0; bus.i_m1_wren = 0; bus.i_m1_addr = 0; bus.i_m1_wdata = 0; bus.i_m1_bmask = 0;
    bus.i_s_ack = 0; bus.i_s_rdata = 0;
  endtask

  task automatic set_m0(input logic wren, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] bm);
    bus.i_m0_req = 1; bus.i_m0_wren = wren; bus.i_m0_addr = addr; bus.i_m0_wdata = wdata; bus.i_m0_bmask = bm;
  endtask

  task automatic set_m1(input logic wren, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] bm);
    bus.i_m1_req = 1; bus.i_m1_wren = wren; bus.i_m1_addr = addr; bus.i_m1_wdata = wdata; bus.i_m1_bmask = bm;
  endtask

  // Called in BUSY cycle 1; the controller acks in BUSY cycle k with data d.
  // Returns in the IDLE cycle right after the ack.
  task automatic ctrl_ack(input int k, input logic [31:0] d);
    repeat (k - 1) tick();
    bus.i_s_ack = 1; bus.i_s_rdata = d;
    tick();
    bus.i_s_ack = 0; bus.i_s_rdata = 0;
  endtask

  // ---------------- reference model ----------------
  // owner: -1 idle, 0/1 master; cyc: 1-based index of the current BUSY cycle.
  int          m_owner;
  int          m_cyc;
  int          m_last;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_bmask;
  logic        m_wren;

  task automatic model_reset();
    m_owner = -1; m_cyc = 0; m_last = 1;
    m_addr = 0; m_wdata = 0; m_bmask = 0; m_wren = 0;
  endtask

  initial begin : compare
    logic        hit, tout, done;
    logic        e_ack0, e_ack1, e_err0, e_err1, e_wr, e_rd, e_busy;
    logic [31:0] e_rd0, e_rd1;
    logic [W-1:0] got, want;
    int          winner;
    model_reset();
    forever begin
      @(negedge i_clk);
      if (i_rst) model_reset();
      e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0; e_wr = 0; e_rd = 0; e_busy = 0;
      e_rd0 = 0; e_rd1 = 0; hit = 0; tout = 0; done = 0;
      if (m_owner >= 0) begin
        hit  = bus.i_s_ack;
        tout = !hit && (m_cyc == TIMEOUT + 1);
        done = hit || tout;
        e_busy = 1;
        if (!tout) begin
          e_wr = m_wren;
          e_rd = !m_wren;
        end
        if (m_owner == 0) begin
          e_ack0 = done; e_err0 = tout; e_rd0 = hit ? bus.i_s_rdata : 32'd0;
        end else begin
          e_ack1 = done; e_err1 = tout; e_rd1 = hit ? bus.i_s_rdata : 32'd0;
        end
      end
      chk("m_busy",   34'(bus.o_busy),    34'(e_busy));
      chk("m_s_wren", 34'(bus.o_s_wren),  34'(e_wr));
      chk("m_s_rden", 34'(bus.o_s_rden),  34'(e_rd));
      chk("m_s_addr", 34'(bus.o_s_addr),  34'(m_addr));
      chk("m_s_wdata",34'(bus.o_s_wdata), 34'(m_wdata));
      chk("m_s_bmask",34'(bus.o_s_bmask), 34'(m_bmask));
      chk("m_ack0",   34'(bus.o_m0_ack),  34'(e_ack0));
      chk("m_err0",   34'(bus.o_m0_err),  34'(e_err0));
      chk("m_rdata0", 34'(bus.o_m0_rdata),34'(e_rd0));
      chk("m_ack1",   34'(bus.o_m1_ack),  34'(e_ack1));
      chk("m_err1",   34'(bus.o_m1_err),  34'(e_err1));
      chk("m_rdata1", 34'(bus.o_m1_rdata),34'(e_rd1));
      // scoreboard of completions expected by the directed scenarios
      if (bus.o_m0_ack || bus.o_m1_ack) begin
        got = bus.o_m1_ack ? {1'b1, bus.o_m1_err, bus.o_m1_rdata}
                           : {1'b0, bus.o_m0_err, bus.o_m0_rdata};
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_ack", got, '0);
        end else begin
          want = exp_q.pop_front();
          chk("sb_completion", got, want);
        end
      end
      if (bus.o_s_rden) n_rden++;
      if (bus.o_m0_ack) n_ack0++;
      if (bus.o_m1_ack) n_ack1++;
      // advance the model across the coming edge
      if (!i_rst) begin
        if (m_owner < 0) begin
          winner = -1;
          if (bus.i_m0_req && bus.i_m1_req) winner = 1 - m_last;
          else if (bus.i_m0_req)            winner = 0;
          else if (bus.i_m1_req)            winner = 1;
          if (winner == 0) begin
            m_addr = bus.i_m0_addr; m_wdata = bus.i_m0_wdata; m_bmask = bus.i_m0_bmask; m_wren = bus.i_m0_wren;
          end else if (winner == 1) begin
            m_addr = bus.i_m1_addr; m_wdata = bus.i_m1_wdata; m_bmask = bus.i_m1_bmask; m_wren = bus.i_m1_wren;
          end
          if (winner >= 0) begin
            m_owner = winner; m_last = winner; m_cyc = 1;
          end
        end else if (done) begin
          m_owner = -1;
        end else begin
          m_cyc++;
        end
      end
    end
  end

  // ---------------- global time limit ----------------
  initial begin
    #200000;
    $display("FAIL sim_time_limit: run did not finish within 200000 time units");
    $fatal(1, "time limit");
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int b_rden, b_ack0, b_ack1;
    i_rst = 1;
    clear_inputs();
    #2;
    chk("rst_busy",  34'(bus.o_busy),   34'd0);
    chk("rst_wren",  34'(bus.o_s_wren), 34'd0);
    chk("rst_rden",  34'(bus.o_s_rden), 34'd0);
    chk("rst_addr",  34'(bus.o_s_addr), 34'd0);
    chk("rst_ack0",  34'(bus.o_m0_ack), 34'd0);
    chk("rst_ack1",  34'(bus.o_m1_ack), 34'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 0;
    tick();

    // Single read, ack on 3rd BUSY cycle
    b_rden = n_rden; b_ack0 = n_ack0; b_ack1 = n_ack1;
    set_m0(1'b0, 32'h0000_2010, 32'd0, 4'hF);
    tick();
    chk("rd_rden",  34'(bus.o_s_rden), 34'd1);
    chk("rd_addr",  34'(bus.o_s_addr), 34'h0000_2010);
    exp_q.push_back({1'b0, 1'b0, 32'hDEAD_BEEF});
    ctrl_ack(3, 32'hDEAD_BEEF);
    bus.i_m0_req = 0;
    tick();
    chk("rd_rden_cycles", 34'(n_rden - b_rden), 34'd3);
    chk("rd_m0_acks",     34'(n_ack0 - b_ack0), 34'd1);
    chk("rd_m1_acks",     34'(n_ack1 - b_ack1), 34'd0);

    // Contention after reset: M0, M1, M0, M1
    i_rst = 1;
    tick();
    i_rst = 0;
    set_m0(1'b0, 32'h0000_0100, 32'd0, 4'hF);
    set_m1(1'b0, 32'h0000_0200, 32'd0, 4'hF);
    tick();
    chk("ct_g1_addr", 34'(bus.o_s_addr), 34'h0000_0100);
    exp_q.push_back({1'b0, 1'b0, 32'hA000_0001});
    ctrl_ack(1, 32'hA000_0001);
    tick();
    chk("ct_g2_addr", 34'(bus.o_s_addr), 34'h0000_0200);
    exp_q.push_back({1'b1, 1'b0, 32'hB000_0001});
    ctrl_ack(2, 32'hB000_0001);
    tick();
    chk("ct_g3_addr", 34'(bus.o_s_addr), 34'h0000_0100);
    exp_q.push_back({1'b0, 1'b0, 32'hA000_0002});
    ctrl_ack(1, 32'hA000_0002);
    tick();
    chk("ct_g4_addr", 34'(bus.o_s_addr), 34'h0000_0200);
    exp_q.push_back({1'b1, 1'b0, 32'hB000_0002});
    ctrl_ack(1, 32'hB000_0002);
    bus.i_m0_req = 0; bus.i_m1_req = 0;
    tick();

    // Write latching: M1 changes its command while BUSY
    set_m1(1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011);
    tick();
    bus.i_m1_addr = 32'hFFFF_0000; bus.i_m1_wdata = 32'h0; bus.i_m1_bmask = 4'hF;
    tick();
    chk("wr_addr",  34'(bus.o_s_addr),  34'h0000_2004);
    chk("wr_wdata", 34'(bus.o_s_wdata), 34'h1234_5678);
    chk("wr_bmask", 34'(bus.o_s_bmask), 34'b0011);
    chk("wr_wren",  34'(bus.o_s_wren),  34'd1);
    chk("wr_rden",  34'(bus.o_s_rden),  34'd0);
    exp_q.push_back({1'b1, 1'b0, 32'h0000_0055});
    ctrl_ack(2, 32'h0000_0055);
    bus.i_m1_req = 0;
    tick();

    // Timeout: no ack, fires in BUSY cycle TIMEOUT+1 = 5
    set_m0(1'b0, 32'h0000_0040, 32'd0, 4'hF);
    bus.i_s_rdata = 32'h0000_0077;
    tick();
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    repeat (4) tick();
    chk("to_ack",   34'(bus.o_m0_ack),   34'd1);
    chk("to_err",   34'(bus.o_m0_err),   34'd1);
    chk("to_rdata", 34'(bus.o_m0_rdata), 34'd0);
    chk("to_rden",  34'(bus.o_s_rden),   34'd0);
    tick();
    bus.i_m0_req = 0; bus.i_s_rdata = 0;
    #1 chk("to_idle", 34'(bus.o_busy), 34'd0);
    tick();

    // Ack and timeout in the same cycle: ack wins
    set_m1(1'b0, 32'h0000_0080, 32'd0, 4'hF);
    tick();
    exp_q.push_back({1'b1, 1'b0, 32'hCAFE_F00D});
    repeat (4) tick();
    bus.i_s_ack = 1; bus.i_s_rdata = 32'hCAFE_F00D;
    #1;
    chk("tie_ack",   34'(bus.o_m1_ack),   34'd1);
    chk("tie_err",   34'(bus.o_m1_err),   34'd0);
    chk("tie_rdata", 34'(bus.o_m1_rdata), 34'hCAFE_F00D);
    tick();
    bus.i_s_ack = 0; bus.i_s_rdata = 0; bus.i_m1_req = 0;
    tick();

    // Reset during BUSY1 cycle 2, then a tie goes to M0
    b_ack1 = n_ack1;
    set_m1(1'b0, 32'h0000_0300, 32'd0, 4'hF);
    tick();
    tick();
    #1 i_rst = 1;
    #1;
    chk("rm_rden", 34'(bus.o_s_rden), 34'd0);
    chk("rm_busy", 34'(bus.o_busy),   34'd0);
    set_m0(1'b0, 32'h0000_0400, 32'd0, 4'hF);
    @(posedge i_clk);
    #1 i_rst = 0;
    chk("rm_no_ack", 34'(n_ack1 - b_ack1), 34'd0);
    tick();
    chk("rm_tie_addr", 34'(bus.o_s_addr), 34'h0000_0400);
    exp_q.push_back({1'b0, 1'b0, 32'h0000_1111});
    ctrl_ack(1, 32'h0000_1111);
    bus.i_m0_req = 0;
    tick();
    chk("rm_m1_addr", 34'(bus.o_s_addr), 34'h0000_0300);
    exp_q.push_back({1'b1, 1'b0, 32'h0000_2222});
    ctrl_ack(2, 32'h0000_2222);
    bus.i_m1_req = 0;
    tick();

    // Stale ack in IDLE
    bus.i_s_ack = 1; bus.i_s_rdata = 32'h0000_0099;
    #1;
    chk("st_ack0", 34'(bus.o_m0_ack), 34'd0);
    chk("st_ack1", 34'(bus.o_m1_ack), 34'd0);
    tick();
    bus.i_s_ack = 0; bus.i_s_rdata = 0;
    chk("st_busy", 34'(bus.o_busy), 34'd0);
    repeat (2) tick();

    chk("sb_drained", 34'(exp_q.size()), 34'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-master arbiter that shares the single SRAM controller between the instruction-fetch port (M0) and the LSU data port (M1). It sits between both masters and `sram_controller`. It grants the bus round-robin, latches the winning master's command and holds the controller strobes until the controller acknowledges. A watchdog aborts any access the controller fails to acknowledge within a bounded time.

## Interface
- `TIMEOUT`, default 255: cycles in BUSY without `i_s_ack` before the access is aborted; legal range 1..255.
- `i_clk`  in  1  single clock; all logic on its rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_m0_req`, `i_m1_req`  in  1 each  request levels; held high until the matching ack.
- `i_m0_wren`, `i_m1_wren`  in  1 each  1 = write, 0 = read.
- `i_m0_addr`, `i_m1_addr`  in  32 each  byte address.
- `i_m0_wdata`, `i_m1_wdata`  in  32 each  store data.
- `i_m0_bmask`, `i_m1_bmask`  in  4 each  byte-lane enables.
- `o_m0_ack`, `o_m1_ack`  out  1 each  one-cycle completion pulse.
- `o_m0_rdata`, `o_m1_rdata`  out  32 each  read data, valid when the matching ack is high.
- `o_m0_err`, `o_m1_err`  out  1 each  high together with ack when the access timed out.
- `o_s_addr`  out  32  latched address to the controller.
- `o_s_wdata`  out  32  latched write data to the controller.
- `o_s_bmask`  out  4  latched byte mask to the controller.
- `o_s_wren`, `o_s_rden`  out  1 each  controller strobes.
- `i_s_rdata`  in  32  controller read data.
- `i_s_ack`  in  1  controller completion.
- `o_busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE
  - BUSY0: M0 owns the bus.
  - BUSY1: M1 owns the bus.
- Priority register `last`, 1 bit, holds the most recently granted master. Reset value is 1, so M0 wins the first tie.
- In IDLE:
  - If exactly one request is high, grant that master.
  - If both are high, grant `!last`.
  - If none is high, stay in IDLE.
- Grant edge (IDLE -> BUSYx):
  - Latch addr, wdata, bmask and wren of master x into the command registers.
  - Set `last` = x.
  - Clear the watchdog counter.
- In BUSYx:
  - `o_s_wren` = latched wren and `o_s_rden` = !latched wren. Exactly one strobe is high.
  - Both strobes are 0 in IDLE.
- On `i_s_ack` in BUSYx:
  - `o_mx_ack` = 1 and `o_mx_rdata` = `i_s_rdata`, combinationally in the same cycle.
  - Next state is IDLE.
- Watchdog:
  - 8-bit counter increments every BUSY cycle without `i_s_ack`.
  - When the counter equals `TIMEOUT`, assert `o_mx_ack` = 1, `o_mx_err` = 1 and `o_mx_rdata` = 0 for that cycle, and drop the strobes.
  - Next state is IDLE.
- Master rule: a master drops req, or presents a new command, in the cycle after its ack. A req still high in that cycle is a new request.
- The non-owning master's ack, err and rdata are 0.
- Requests that change while the bus is BUSY are ignored until the next IDLE. Command registers do not change during BUSY.
- A late `i_s_ack` arriving while in IDLE is ignored.

## Timing
- Reset values:
  - state = IDLE, `last` = 1, counter = 0, command registers = 0.
  - All outputs are 0, including `o_s_*`, every ack, rdata and err, and `o_busy`.
- Reset mid-access: return to IDLE immediately and drop the strobes asynchronously. No ack is issued for the aborted access.
- Grant latency: a req seen in IDLE at edge N puts the arbiter in BUSY with strobes high in cycle N+1.
- Arbitration overhead is one IDLE cycle. With a controller ack at cycle k of BUSY, back-to-back accesses cost k+1 cycles each.
- Ack is combinational from `i_s_ack`. There is no added latency on the return path.
- Timeout fires in the cycle the counter reaches `TIMEOUT`, i.e. the (`TIMEOUT`+1)th BUSY cycle.
- If `i_s_ack` and the timeout hit in the same cycle, the ack wins: err = 0 and data passes through.

## Test plan
- Single read: M0 req, addr 0x0000_2010, wren = 0; controller acks on the 3rd BUSY cycle with rdata 0xDEAD_BEEF -> `o_s_rden` high for 3 cycles, `o_s_addr` = 0x0000_2010, `o_m0_ack` pulses once with 0xDEAD_BEEF, `o_m1_ack` stays 0.
- Simultaneous contention: after reset, both request on the same cycle -> M0 is granted first. With both held continuously, grants alternate M1, M0, M1. Each master gets ack with its own rdata.
- Write latching: M1 writes addr 0x0000_2004, wdata 0x1234_5678, bmask 4'b0011; M1 changes addr and wdata during BUSY -> `o_s_*` keep the original values and `o_s_wren` = 1 until ack.
- Timeout: with `TIMEOUT` = 4, the controller never acks -> `o_m0_ack` and `o_m0_err` are 1 in the 5th BUSY cycle, rdata is 0, and the arbiter is back in IDLE next cycle. An ack and the timeout in the same cycle -> err = 0.
- Reset mid-access: assert `i_rst` in cycle 2 of BUSY1 -> strobes and `o_busy` drop asynchronously and no ack is issued. After release, a pending M0/M1 tie grants M0.
- Stale ack: pulse `i_s_ack` while IDLE -> no master ack and no state change.
